// File: rtl/neuron_feeder.sv
// neuron_feeder: stream front end for an external combinational neuron.
//   Assembles one frame of 2N+1 signed operand words (x0,w0,...,x_{N-1},w_{N-1},b)
//   into the packed nn_x/nn_w/nn_b vectors, then captures nn_y and offers it
//   on a valid/ready result port. Result is visible 2 cycles after the bias
//   handshake; min frame period 2N+3 cycles.
// Backpressure: s_ready is high only while loading (registered state only);
//   words offered while a result is pending are left with the source.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   s_data/s_valid/s_ready   - operand word stream in
//   nn_x, nn_w, nn_b         - packed operands to the neuron (x_k at [k*WIDTH +: WIDTH])
//   nn_y                     - neuron output (post-ReLU, signed)
//   r_data/r_valid/r_ready   - captured result out
//   r_sat                    - captured result was clamped
// Build option: define NEURON_FEEDER_SAT_EN to clamp results above 2^WIDTH-1
//   and flag them on r_sat; otherwise nn_y passes through and r_sat is 0.

module neuron_feeder #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [N*WIDTH-1:0]   nn_x,
  output logic [N*WIDTH-1:0]   nn_w,
  output logic [WIDTH-1:0]     nn_b,
  input  logic [2*WIDTH+1:0]   nn_y,
  output logic [2*WIDTH+1:0]   r_data,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic                 r_sat
);

  localparam int IDX_W = $clog2(2*N+1);
  localparam int YW    = 2*WIDTH+2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2*N);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N*WIDTH-1:0]   x_q, x_d;
  logic [N*WIDTH-1:0]   w_q, w_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [YW-1:0]        res_q, res_d;
  logic                 sat_q, sat_d;
  logic                 accept;
  logic [YW-1:0]        y_cap;
  logic                 y_sat;

  assign s_ready = (state_q == LOAD);
  assign accept  = s_valid && s_ready;

  // Value that will be latched on the SETTLE->OUT edge.
`ifdef NEURON_FEEDER_SAT_EN
  localparam logic [YW-1:0] SAT_MAX = YW'((1 << WIDTH) - 1);

  always_comb begin
    y_cap = nn_y;
    y_sat = 1'b0;
    // Signed compare so a (non-ReLU) negative value is never treated as large.
    if ($signed(nn_y) > $signed(SAT_MAX)) begin
      y_cap = SAT_MAX;
      y_sat = 1'b1;
    end
  end
`else
  assign y_cap = nn_y;
  assign y_sat = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    w_d     = w_q;
    b_d     = b_q;
    res_d   = res_q;
    sat_d   = sat_q;

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            b_d     = s_data;
            state_d = SETTLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      // One cycle for the neuron to see the freshly written bias.
      SETTLE: begin
        res_d   = y_cap;
        sat_d   = y_sat;
        state_d = OUT;
      end
      OUT: begin
        if (r_ready) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    // Even word 2k -> x_k, odd word 2k+1 -> w_k.
    for (int k = 0; k < N; k++) begin
      if (accept && (idx_q == IDX_W'(2*k)))
        x_d[k*WIDTH +: WIDTH] = s_data;
      if (accept && (idx_q == IDX_W'(2*k+1)))
        w_d[k*WIDTH +: WIDTH] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      w_q     <= w_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

  assign nn_x    = x_q;
  assign nn_w    = w_q;
  assign nn_b    = b_q;
  assign r_data  = res_q;
  assign r_sat   = sat_q;
  assign r_valid = (state_q == OUT);

endmodule

// File: doc/neuron_feeder.md
# neuron_feeder

Stream-side front end for the combinational `neuron` block (parameters N, WIDTH; `y = ReLU(sum(x_i*w_i) + b)`).
- Accepts one operand word per handshake on a valid/ready input stream and assembles the packed `x`, `w` and `b` vectors that drive the neuron.
- Captures the neuron's `y` one cycle after the frame completes and returns it on a valid/ready result port.
- Sits between the upstream operand source and the `neuron` instance, which is connected externally through the `nn_*` ports.

## Interface
- `N`, default 4: inputs per neuron; a frame is 2N+1 words.
- `WIDTH`, default 8: operand width (signed two's complement).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in WIDTH: operand word (signed).
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: block accepts a word this cycle.
- `nn_x` out N*WIDTH: packed inputs; `x_k` at `[k*WIDTH +: WIDTH]`.
- `nn_w` out N*WIDTH: packed weights; `w_k` at `[k*WIDTH +: WIDTH]`.
- `nn_b` out WIDTH: bias.
- `nn_y` in 2*WIDTH+2: neuron output (signed, non-negative after ReLU).
- `r_data` out 2*WIDTH+2: captured result.
- `r_valid` out 1: result valid.
- `r_ready` in 1: consumer accepts the result.
- `r_sat` out 1: the captured result was clamped (see Configuration).

## Operation
- Frame word order:
  - Words 0..2N-1 are `x0, w0, x1, w1, …, x_{N-1}, w_{N-1}`.
  - Word 2N is `b`.
  - Even word 2k is written to the `x_k` slot; odd word 2k+1 is written to the `w_k` slot.
- A word index counter `idx` runs from 0 to 2N. It increments only when `s_valid && s_ready`, and clears to 0 on every return to LOAD.
- FSM states and transitions:
  - LOAD: `s_ready` = 1. The handshake that accepts word 2N moves the state to SETTLE.
  - SETTLE: `s_ready` = 0. Unconditionally moves to OUT. `r_data` and `r_sat` are captured on the SETTLE→OUT edge.
  - OUT: `r_valid` = 1, `s_ready` = 0. When `r_ready` = 1, moves to LOAD.
- `nn_x`, `nn_w` and `nn_b` hold their last written values between frames. They are not cleared on frame completion.
- Words offered on `s_valid` outside LOAD are not accepted and must be held by the source.
- `s_valid` may drop between words; gaps do not affect frame assembly.
- `r_data` is the zero-extended non-negative value of `nn_y` (subject to the Configuration feature).

## Timing
- Reset values: `s_ready` = 1 (state LOAD), `r_valid` = 0, `r_data` = 0, `r_sat` = 0, `nn_x` = 0, `nn_w` = 0, `nn_b` = 0, `idx` = 0.
- Word write timing: a word accepted at edge E is visible on `nn_*` after E.
- Latency for a bias accepted at edge E0:
  - E1: capture into `r_data`.
  - After E1: `r_valid` = 1.
  - First cycle with `r_valid` = 1 occurs 2 cycles after the bias handshake.
- Result handshake at edge E2 (`r_valid && r_ready`): after E2, `r_valid` = 0 and `s_ready` = 1. The minimum frame period is therefore 2N+3 cycles.
- `r_data` and `r_sat` are stable while `r_valid` = 1 and `r_ready` = 0.
- `s_ready` is a function of registered state only; there is no combinational path from `r_ready`.
- Reset asserted mid-frame or in OUT: the partial frame or pending result is discarded and all registers return to their reset values on that edge.
- `rst` dominates a simultaneous handshake.

## Configuration
- Macro: `NEURON_FEEDER_SAT_EN`.
- Defined: at capture, if `nn_y` > 2^WIDTH−1, then `r_data` = 2^WIDTH−1 (upper bits 0) and `r_sat` = 1. Otherwise `r_data` = `nn_y` and `r_sat` = 0.
- Undefined: `r_data` = `nn_y` unmodified and `r_sat` is tied to 0.
- The port list is identical in both builds.

## Test plan
1. Frame `x` = {1,2,3,4}, `w` = {1,1,1,1}, `b` = 5, with `s_valid` continuous and `r_ready` = 1 → `r_valid` asserted 2 cycles after the bias handshake, `r_data` = 15, `s_ready` = 1 the following cycle.
2. Frame `x` = {2,2,2,2}, `w` = {−1,−1,−1,−1}, `b` = −1 → `r_data` = 0 (ReLU of −9), `r_sat` = 0.
3. Frame `x` = {1,2,−3,5}, `w` = {5,4,3,2}, `b` = 3, with a 3-cycle `s_valid` gap after word 4 → `nn_x`/`nn_w` slots match the word order, `r_data` = 17.
4. Backpressure: repeat scenario 3 with `r_ready` low for 5 cycles → `r_valid` stays 1, `r_data` stays 17, `s_ready` stays 0, and a word held on `s_valid` is not consumed until after the result handshake.
5. Frame `x` = {127,127,127,127}, `w` = {127,127,127,127}, `b` = 127 → with `NEURON_FEEDER_SAT_EN`: `r_data` = 255, `r_sat` = 1. Without it: `r_data` = 64643, `r_sat` = 0.
6. Assert `rst` for 1 cycle after 3 accepted words → all outputs at reset values and `idx` = 0; the next full frame from scenario 1 yields `r_data` = 15.
